// File: rtl/alu_bus_master_pkg.sv
// alu_bus_master_pkg: slave register map, done code and FSM encoding shared by the bus master.
package alu_bus_master_pkg;
   localparam logic [7:0] ADDR_OPA    = 8'd0;
   localparam logic [7:0] ADDR_OPB    = 8'd1;
   localparam logic [7:0] ADDR_OPCODE = 8'd2;
   localparam logic [7:0] ADDR_RES1   = 8'd3;
   localparam logic [7:0] ADDR_RES2   = 8'd4;
   localparam logic [7:0] ADDR_START  = 8'd5;
   localparam logic [7:0] ADDR_DONE   = 8'd6;
   localparam logic [7:0] ADDR_CLEAR  = 8'd7;
   localparam logic [1:0] DONE_CODE   = 2'b11;
   typedef enum logic [3:0] {
      S_IDLE, S_WR_A, S_WR_B, S_WR_OP, S_WR_START, S_POLL_REQ, S_POLL_WAIT,
      S_R1_REQ, S_R1_WAIT, S_R2_REQ, S_R2_WAIT, S_WR_CLR, S_RESP
   } state_t;
endpackage

// File: rtl/alu_bus_beat.sv
// alu_bus_beat: registers one slave bus beat (write or read request); bus idles at all-zero.
module alu_bus_beat (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_go,
   input  logic        i_wr,
   input  logic [7:0]  i_addr,
   input  logic [31:0] i_data,
   output logic        o_sel,
   output logic        o_wr,
   output logic [7:0]  o_addr,
   output logic [31:0] o_din
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_sel  <= 1'b0;
         o_wr   <= 1'b0;
         o_addr <= '0;
         o_din  <= '0;
      end else begin
         o_sel  <= i_go;
         o_wr   <= i_go & i_wr;
         o_addr <= i_go ? i_addr : '0;
         o_din  <= (i_go & i_wr) ? i_data : '0;
      end
   end
endmodule

// File: rtl/alu_bus_master.sv
// alu_bus_master: turns one host command into the write/start/poll/read/clear
// transaction of the memory-mapped ALU slave and returns both result words.
module alu_bus_master
   import alu_bus_master_pkg::*;
#(
   parameter int MAX_POLLS = 256,
   parameter int POLL_CW   = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [3:0]  cmd_op,
   output logic        rsp_valid,
   output logic [31:0] rsp_result1,
   output logic [31:0] rsp_result2,
   output logic        rsp_timeout,
   output logic        S_sel,
   output logic        S_wr,
   output logic [7:0]  S_addr,
   output logic [31:0] S_din,
   input  logic [31:0] S_dout
);
   localparam logic [POLL_CW-1:0] LP_MAX = POLL_CW'(MAX_POLLS);
   state_t               r_state, w_state_nx;
   logic [31:0]          r_a, r_b, r_res1, r_res2, w_a, w_data;
   logic [3:0]           r_op;
   logic [POLL_CW-1:0]   r_polls, w_polls_inc;
   logic                 r_to, w_accept, w_done, w_go, w_wr;
   logic [7:0]           w_addr;
   assign w_accept    = (r_state == S_IDLE) && cmd_valid;
   assign w_done      = S_dout[1:0] == DONE_CODE;
   assign w_polls_inc = r_polls + 1'b1;
   // operand A is written on the very edge it is latched, so bypass the register
   assign w_a         = w_accept ? cmd_a : r_a;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end
   always_comb begin
      w_state_nx = S_IDLE;
      case (r_state)
         S_IDLE:      w_state_nx = w_accept ? S_WR_A : S_IDLE;
         S_WR_A:      w_state_nx = S_WR_B;
         S_WR_B:      w_state_nx = S_WR_OP;
         S_WR_OP:     w_state_nx = S_WR_START;
         S_WR_START:  w_state_nx = S_POLL_REQ;
         S_POLL_REQ:  w_state_nx = S_POLL_WAIT;
         S_POLL_WAIT: w_state_nx = w_done ? S_R1_REQ : (w_polls_inc == LP_MAX) ? S_WR_CLR : S_POLL_REQ;
         S_R1_REQ:    w_state_nx = S_R1_WAIT;
         S_R1_WAIT:   w_state_nx = S_R2_REQ;
         S_R2_REQ:    w_state_nx = S_R2_WAIT;
         S_R2_WAIT:   w_state_nx = S_WR_CLR;
         S_WR_CLR:    w_state_nx = S_RESP;
         default:     w_state_nx = S_IDLE;
      endcase
   end
   // beat request is decoded from the next state so the registered bus lines up with it
   always_comb begin
      w_go   = 1'b1;
      w_wr   = 1'b1;
      w_addr = '0;
      w_data = '0;
      case (w_state_nx)
         S_WR_A:     begin w_addr = ADDR_OPA;    w_data = w_a;           end
         S_WR_B:     begin w_addr = ADDR_OPB;    w_data = r_b;           end
         S_WR_OP:    begin w_addr = ADDR_OPCODE; w_data = {28'b0, r_op}; end
         S_WR_START: begin w_addr = ADDR_START;  w_data = 32'h1;         end
         S_WR_CLR:   begin w_addr = ADDR_CLEAR;  w_data = 32'h1;         end
         S_POLL_REQ: begin w_wr = 1'b0; w_addr = ADDR_DONE; end
         S_R1_REQ:   begin w_wr = 1'b0; w_addr = ADDR_RES1; end
         S_R2_REQ:   begin w_wr = 1'b0; w_addr = ADDR_RES2; end
         default:    begin w_go = 1'b0; w_wr = 1'b0; end
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_polls     <= '0;
         r_to        <= 1'b0;
         r_res1      <= '0;
         r_res2      <= '0;
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_result1 <= '0;
         rsp_result2 <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         cmd_ready <= w_state_nx == S_IDLE;
         rsp_valid <= w_state_nx == S_RESP;
         if (w_accept) begin
            r_a         <= cmd_a;
            r_b         <= cmd_b;
            r_op        <= cmd_op;
            r_polls     <= '0;
            r_to        <= 1'b0;
            r_res1      <= '0;
            r_res2      <= '0;
            rsp_timeout <= 1'b0;
         end
         if (r_state == S_POLL_WAIT && !w_done) begin
            r_polls <= w_polls_inc;
            r_to    <= w_polls_inc == LP_MAX;
         end
         if (r_state == S_R1_WAIT) r_res1 <= S_dout;
         if (r_state == S_R2_WAIT) r_res2 <= S_dout;
         if (w_state_nx == S_RESP) begin
            rsp_result1 <= r_res1;
            rsp_result2 <= r_res2;
            rsp_timeout <= r_to;
         end
      end
   end
   alu_bus_beat u_beat (
      .clk    (clk),
      .reset  (reset),
      .i_go   (w_go),
      .i_wr   (w_wr),
      .i_addr (w_addr),
      .i_data (w_data),
      .o_sel  (S_sel),
      .o_wr   (S_wr),
      .o_addr (S_addr),
      .o_din  (S_din)
   );
endmodule

// File: tb/tb_alu_bus_master.sv
// tb_alu_bus_master: random and directed host commands against a behavioural ALU slave,
// with a response scoreboard and a bus-beat scoreboard checked by independent monitors.
module tb_alu_bus_master;
   localparam int MAXP = 4;
   logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
   logic [31:0] cmd_a = '0, cmd_b = '0;
   logic [3:0]  cmd_op = '0;
   logic        cmd_ready, rsp_valid, rsp_timeout, S_sel, S_wr;
   logic [31:0] rsp_result1, rsp_result2, S_din;
   logic [31:0] S_dout = '0;
   logic [7:0]  S_addr;
   typedef struct {logic [31:0] r1; logic [31:0] r2; logic to; int c0; int lat;} rsp_t;
   typedef struct {logic wr; logic [7:0] addr; logic [31:0] data;} beat_t;
   rsp_t  sb[$];
   beat_t bq[$];
   int    pq[$];
   int    tests = 0, fails = 0, cyc = 0, last_rsp = -100;
   bit    skip_bus = 1'b0;
   logic [31:0] sr_a = '0, sr_b = '0, sr_r1 = '0, sr_r2 = '0;
   logic [3:0]  sr_op = '0;
   int          cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_bus_master #(.MAX_POLLS(MAXP), .POLL_CW(3)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(rsp_valid),
      .rsp_result1(rsp_result1), .rsp_result2(rsp_result2), .rsp_timeout(rsp_timeout),
      .S_sel(S_sel), .S_wr(S_wr), .S_addr(S_addr), .S_din(S_din), .S_dout(S_dout)
   );

   function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      logic [31:0] s;
      case (op)
         4'd0:    s = a + b;
         4'd1:    s = a - b;
         4'd2:    return 64'(a) * 64'(b);
         4'd3:    s = a & b;
         default: s = a ^ b;
      endcase
      return {32'b0, s};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave: results appear on S_dout only in the cycle after a read request, garbage otherwise.
   always @(posedge clk) begin
      if (reset) begin
         cnt    <= 0;
         S_dout <= $urandom;
      end else begin
         S_dout <= $urandom;
         if (S_sel && S_wr) begin
            case (S_addr)
               8'd0: sr_a  <= S_din;
               8'd1: sr_b  <= S_din;
               8'd2: sr_op <= S_din[3:0];
               8'd5: begin
                  {sr_r2, sr_r1} <= ref_alu(sr_a, sr_b, sr_op);
                  cnt <= (pq.size() > 0) ? pq.pop_front() : 0;
               end
               8'd7: begin sr_r1 <= '0; sr_r2 <= '0; cnt <= 0; end
               default: ;
            endcase
         end
         if (S_sel && !S_wr) begin
            case (S_addr)
               8'd3: S_dout <= sr_r1;
               8'd4: S_dout <= sr_r2;
               8'd6: begin
                  if (cnt == 1) S_dout <= ($urandom & ~32'h3) | 32'h3;
                  else          S_dout <= ($urandom & ~32'h3) | 32'($urandom_range(0, 2));
                  if (cnt > 1) cnt <= cnt - 1;
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      beat_t e;
      if (!reset && S_sel && !skip_bus) begin
         if (bq.size() == 0) begin
            tests++; fails++;
            $display("FAIL bus_unexpected: got beat addr %0h wr %0b expected none", S_addr, S_wr);
         end else begin
            e = bq.pop_front();
            chk("bus_wr", 64'(S_wr), 64'(e.wr));
            chk("bus_addr", 64'(S_addr), 64'(e.addr));
            if (e.wr) chk("bus_din", 64'(S_din), 64'(e.data));
         end
      end
   end

   always @(negedge clk) begin
      rsp_t e;
      if (!reset && rsp_valid) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL rsp_unexpected: got rsp_valid expected none");
         end else begin
            e = sb.pop_front();
            chk("rsp_result1", 64'(rsp_result1), 64'(e.r1));
            chk("rsp_result2", 64'(rsp_result2), 64'(e.r2));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
            chk("rsp_latency", 64'(cyc - e.c0), 64'(e.lat));
         end
         last_rsp = cyc;
      end
   end

   // p = polls until done (0 = never); track=0 issues a command that will be aborted.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input int p, input bit b2b, input bit keep, input bit track);
      bit to;
      int n, guard;
      logic [63:0] r;
      to = (p == 0) || (p > MAXP);
      n  = to ? MAXP : p;
      r  = ref_alu(a, b, op);
      pq.push_back(p);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
      guard = 0;
      while (!cmd_ready && guard < 200) begin @(negedge clk); guard++; end
      if (!cmd_ready) begin
         tests++; fails++;
         $display("FAIL accept_timeout: got cmd_ready 0 expected 1");
         cmd_valid = 1'b0;
         return;
      end
      if (b2b) chk("b2b_accept", 64'(cyc), 64'(last_rsp + 1));
      if (track) begin
         sb.push_back('{to ? 32'h0 : r[31:0], to ? 32'h0 : r[63:32], to, cyc, 4 + 2 * n + (to ? 0 : 4) + 2});
         bq.push_back('{1'b1, 8'd0, a});
         bq.push_back('{1'b1, 8'd1, b});
         bq.push_back('{1'b1, 8'd2, {28'b0, op}});
         bq.push_back('{1'b1, 8'd5, 32'h1});
         for (int i = 0; i < n; i++) bq.push_back('{1'b0, 8'd6, 32'h0});
         if (!to) begin
            bq.push_back('{1'b0, 8'd3, 32'h0});
            bq.push_back('{1'b0, 8'd4, 32'h0});
         end
         bq.push_back('{1'b1, 8'd7, 32'h1});
      end
      @(posedge clk); #1;
      if (!keep) cmd_valid = 1'b0;
      @(negedge clk);
      chk("timeout_cleared", 64'(rsp_timeout), 64'(0));
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() > 0 && guard < 500) begin @(negedge clk); guard++; end
      if (sb.size() > 0) begin
         tests++; fails++;
         $display("FAIL drain: got %0d pending responses expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_S_sel", 64'(S_sel), 64'(0));
      chk("rst_S_wr", 64'(S_wr), 64'(0));
      chk("rst_S_addr", 64'(S_addr), 64'(0));
      chk("rst_S_din", 64'(S_din), 64'(0));
      chk("rst_results", 64'({rsp_result1, rsp_result2}), 64'(0));
      chk("rst_timeout", 64'(rsp_timeout), 64'(0));
      reset = 1'b0;
      issue(32'h7, 32'h3, 4'h2, 1, 0, 0, 1);
      drain();
      issue($urandom, $urandom, 4'h0, 4, 0, 0, 1);
      drain();
      issue($urandom, $urandom, 4'h1, 0, 0, 0, 1);
      drain();
      chk("timeout_hold", 64'(rsp_timeout), 64'(1));
      issue($urandom, $urandom, 4'h3, 2, 0, 0, 1);
      drain();
      issue(32'h1, 32'h2, 4'h0, 1, 0, 1, 1);
      issue(32'h5, 32'h6, 4'h2, 2, 1, 0, 1);
      drain();
      skip_bus = 1'b1;
      issue($urandom, $urandom, 4'h2, 0, 0, 0, 0);
      guard = 0;
      while (!(S_sel && !S_wr && S_addr == 8'd6) && guard < 50) begin @(negedge clk); guard++; end
      chk("poll_seen", 64'(S_addr), 64'(6));
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("midrst_S_sel", 64'(S_sel), 64'(0));
      chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      pq.delete();
      skip_bus = 1'b0;
      repeat (20) @(negedge clk);
      chk("midrst_cmd_ready_after", 64'(cmd_ready), 64'(1));
      issue($urandom, $urandom, 4'h2, 1, 0, 0, 1);
      drain();
      for (int k = 0; k < 24; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue($urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6), 0, 0, 1);
      end
      drain();
      chk("beats_left", 64'(bq.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
